// File: rtl/ov7670_capture_scaler.sv
// rtl/ov7670_capture_scaler.sv - OV7670 byte-stream capture with format select, decimation, pause and overflow guard
// Optional line-length checker: OV7670_CAPTURE_LINE_CHECK_EN
`timescale 1ns/1ps
module ov7670_capture_scaler #(
   parameter int HRES   = 640,
   parameter int VRES   = 480,
   parameter int ADDR_W = 19
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        din,
   input  logic [1:0]        mode,
   input  logic [1:0]        scale,
   input  logic              pause,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        dout,
   output logic              we,
   output logic              frame_done,
   output logic [7:0]        frame_cnt,
   output logic              overflow,
   output logic              line_err
);

   localparam int XW  = $clog2(HRES + 1);
   localparam int YW  = $clog2(VRES + 1);
   localparam int AW1 = ADDR_W + 1;
   localparam logic [XW-1:0]  HRES_X = XW'(HRES);
   localparam logic [YW-1:0]  VRES_Y = YW'(VRES);
   localparam logic [AW1-1:0] LIM0   = AW1'(HRES * VRES);
   localparam logic [AW1-1:0] LIM1   = AW1'((HRES >> 1) * (VRES >> 1));
   localparam logic [AW1-1:0] LIM2   = AW1'((HRES >> 2) * (VRES >> 2));

   typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE, S_PAUSED} state_t;
   state_t state_q, state_d;

   logic              vsync_q, href_q;
   logic [1:0]        mode_q, scale_q;
   logic              phase_q;
   logic [7:0]        b0_q;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [AW1-1:0]    idx_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        dout_q;
   logic              we_q, fd_q, ovf_q;
   logic [7:0]        cnt_q;

   logic              vs_rise, vs_fall, hr_rise, hr_fall;
   logic              byte_en, cur_phase, pix_done, aligned, full, keep, ovf_hit, frame_start;
   logic [1:0]        smask;
   logic [AW1-1:0]    lim;
   logic [7:0]        gray, pix;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_SYNC:   if (vsync)   state_d = S_VBLANK;
         S_VBLANK: if (vs_fall) state_d = pause ? S_PAUSED : S_ACTIVE;
         S_ACTIVE: if (vs_rise) state_d = S_VBLANK;
         S_PAUSED: if (vs_rise) state_d = S_VBLANK;
         default:               state_d = S_SYNC;
      endcase
   end

   always_comb begin
      vs_rise     = vsync & ~vsync_q;
      vs_fall     = ~vsync & vsync_q;
      hr_rise     = href & ~href_q;
      hr_fall     = ~href & href_q;
      frame_start = (state_q == S_VBLANK) && vs_fall;
      // vsync high overrides href: no bytes are taken during blanking
      byte_en     = (state_q == S_ACTIVE) && href && !vsync;
      cur_phase   = hr_rise ? 1'b0 : phase_q;
      pix_done    = byte_en && cur_phase;
      smask       = (scale_q == 2'd0) ? 2'b00 : (scale_q == 2'd1) ? 2'b01 : 2'b11;
      lim         = (scale_q == 2'd0) ? LIM0 : (scale_q == 2'd1) ? LIM1 : LIM2;
      aligned     = (x_q < HRES_X) && ((x_q[1:0] & smask) == 2'b00) && ((y_q[1:0] & smask) == 2'b00);
      full        = (idx_q >= lim);
      keep        = pix_done && aligned && (y_q < VRES_Y) && !full;
      // extra lines past VRES land here too, so a tall frame flags overflow
      ovf_hit     = pix_done && aligned && full;
      gray        = {2'b00, b0_q[7:3], 1'b0} + {1'b0, b0_q[2:0], din[7:5], 1'b0} + {3'b000, din[4:0]};
      pix         = (mode_q == 2'd1) ? gray : b0_q;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_SYNC;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         mode_q  <= 2'd0;
         scale_q <= 2'd0;
         phase_q <= 1'b0;
         b0_q    <= 8'd0;
         x_q     <= '0;
         y_q     <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         dout_q  <= 8'd0;
         we_q    <= 1'b0;
         fd_q    <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         vsync_q <= vsync;
         href_q  <= href;
         we_q    <= keep;
         fd_q    <= (state_q == S_ACTIVE) && vs_rise;
         if ((state_q == S_ACTIVE) && vs_rise) cnt_q <= cnt_q + 8'd1;
         if (frame_start) begin
            mode_q  <= mode;
            scale_q <= (scale == 2'd3) ? 2'd2 : scale;
            phase_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
         end else begin
            if (byte_en) begin
               phase_q <= ~cur_phase;
               if (!cur_phase) b0_q <= din;
            end
            if (pix_done && (x_q < HRES_X)) x_q <= x_q + 1'b1;
            if ((state_q == S_ACTIVE) && hr_fall) begin
               x_q <= '0;
               if (y_q < VRES_Y) y_q <= y_q + 1'b1;
            end
            if (keep) begin
               addr_q <= idx_q[ADDR_W-1:0];
               dout_q <= pix;
               idx_q  <= idx_q + 1'b1;
            end
            if (ovf_hit) ovf_q <= 1'b1;
         end
      end
   end

`ifdef OV7670_CAPTURE_LINE_CHECK_EN
   localparam int BW = $clog2(2 * HRES + 2) + 1;
   localparam logic [BW-1:0] BYTES_LINE = BW'(2 * HRES);
   localparam logic [BW-1:0] BMAX       = '1;
   logic [BW-1:0] bc_q;
   logic          lerr_q;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         bc_q   <= '0;
         lerr_q <= 1'b0;
      end else if (frame_start) begin
         bc_q   <= '0;
         lerr_q <= 1'b0;
      end else begin
         if (byte_en) bc_q <= hr_rise ? BW'(1) : ((bc_q == BMAX) ? bc_q : bc_q + 1'b1);
         if ((state_q == S_ACTIVE) && hr_fall && !vsync && (bc_q != BYTES_LINE)) lerr_q <= 1'b1;
      end
   end
   assign line_err = lerr_q;
`else
   assign line_err = 1'b0;
`endif

   assign addr       = addr_q;
   assign dout       = dout_q;
   assign we         = we_q;
   assign frame_done = fd_q;
   assign frame_cnt  = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ov7670_capture_scaler.sv
// tb/tb_ov7670_capture_scaler.sv - directed self-checking bench for ov7670_capture_scaler (16x8 frame)
`timescale 1ns/1ps
module tb_ov7670_capture_scaler;
   localparam int HRES = 16, VRES = 8, ADDR_W = 7;

   logic pclk = 1'b0, rst_n, vsync, href, pause;
   logic [7:0] din;
   logic [1:0] mode, scale;
   logic [ADDR_W-1:0] addr;
   logic [7:0] dout, frame_cnt;
   logic we, frame_done, overflow, line_err;

   int errors = 0, checks = 0, nw = 0, nfd = 0, n0, f0;
   logic [ADDR_W-1:0] wa[1024];
   logic [7:0]        wd[1024];

   ov7670_capture_scaler #(.HRES(HRES), .VRES(VRES), .ADDR_W(ADDR_W)) dut (
      .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .din(din),
      .mode(mode), .scale(scale), .pause(pause), .addr(addr), .dout(dout),
      .we(we), .frame_done(frame_done), .frame_cnt(frame_cnt),
      .overflow(overflow), .line_err(line_err));

   always #5 pclk = ~pclk;

   always @(negedge pclk) begin
      if (we === 1'b1) begin
         wa[nw % 1024] = addr;
         wd[nw % 1024] = dout;
         nw++;
      end
      if (frame_done === 1'b1) nfd++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input logic v, input logic h, input logic [7:0] d);
      vsync = v; href = h; din = d;
      @(posedge pclk);
      #1;
   endtask

   function automatic logic [15:0] pixw(input int pat, input int x, input int y);
      if (pat == 0) return {y[3:0], x[3:0], 8'hA5};
      case (x % 4)
         0: return 16'hFFFF;
         1: return 16'hF800;
         2: return 16'h07E0;
         default: return 16'h001F;
      endcase
   endfunction

   task automatic send_pix(input int pat, input int x, input int y, input logic v);
      logic [15:0] w;
      w = pixw(pat, x, y);
      cyc(v, 1'b1, w[15:8]);
      cyc(v, 1'b1, w[7:0]);
   endtask

   task automatic send_line(input int y, input int npix, input int pat);
      for (int x = 0; x < npix; x++) send_pix(pat, x, y, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input int nlines, input int short_pix, input int abort_pix,
                             input int pat, input int tog_line);
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
      for (int l = 0; l < nlines; l++) begin
         if (l == tog_line) begin
            pause = ~pause;
            mode  = 2'd1;
         end
         send_line(l, HRES, pat);
      end
      if (short_pix > 0) send_line(nlines, short_pix, pat);
      if (abort_pix > 0) begin
         for (int x = 0; x < abort_pix; x++) send_pix(pat, x, nlines, 1'b0);
         cyc(1'b1, 1'b1, 8'h11);
         cyc(1'b1, 1'b1, 8'h22);
         cyc(1'b1, 1'b0, 8'h00);
      end
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0; vsync = 1'b0; href = 1'b0; din = 8'h00;
      mode = 2'd0; scale = 2'd0; pause = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_addr", addr, 0);
      chk("rst_dout", dout, 0);
      chk("rst_we", we, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_line_err", line_err, 0);
      rst_n = 1'b1;

      // full frame, Y-only, 1:1
      n0 = nw; f0 = nfd;
      send_frame(8, 0, 0, 0, -1);
      chk("f1_writes", nw - n0, 128);
      chk("f1_done", nfd - f0, 1);
      chk("f1_cnt", frame_cnt, 1);
      for (int i = 0; i < 128; i++) begin
         chk("f1_addr", wa[(n0 + i) % 1024], i);
         chk("f1_dout", wd[(n0 + i) % 1024], i);
      end

      // RGB565 to gray
      mode = 2'd1;
      n0 = nw;
      send_frame(8, 0, 0, 1, -1);
      mode = 2'd0;
      chk("rgb_writes", nw - n0, 128);
      chk("rgb_white", wd[(n0 + 0) % 1024], 219);
      chk("rgb_red", wd[(n0 + 1) % 1024], 62);
      chk("rgb_green", wd[(n0 + 2) % 1024], 126);
      chk("rgb_blue", wd[(n0 + 3) % 1024], 31);
      chk("rgb_red_l1", wd[(n0 + 21) % 1024], 62);
      chk("rgb_cnt", frame_cnt, 2);

      // decimation 1/4
      scale = 2'd2;
      n0 = nw;
      send_frame(8, 0, 0, 0, -1);
      chk("s2_writes", nw - n0, 8);
      chk("s2_addr_max", wa[(n0 + 7) % 1024], 7);
      chk("s2_addr_x4y4", wa[(n0 + 5) % 1024], 5);
      chk("s2_dout_x4y4", wd[(n0 + 5) % 1024], 8'h44);
      chk("s2_dout_x4y0", wd[(n0 + 1) % 1024], 8'h04);
      chk("s2_cnt", frame_cnt, 3);

      // decimation 1/2
      scale = 2'd1;
      n0 = nw;
      send_frame(8, 0, 0, 0, -1);
      scale = 2'd0;
      chk("s1_writes", nw - n0, 32);
      chk("s1_dout_x2y2", wd[(n0 + 9) % 1024], 8'h22);
      chk("s1_dout_last", wd[(n0 + 31) % 1024], 8'h6E);
      chk("s1_cnt", frame_cnt, 4);

      // paused frame
      pause = 1'b1;
      n0 = nw; f0 = nfd;
      send_frame(8, 0, 0, 0, -1);
      pause = 1'b0;
      chk("pause_writes", nw - n0, 0);
      chk("pause_done", nfd - f0, 0);
      chk("pause_cnt", frame_cnt, 4);

      // pause and mode toggled mid-frame are ignored until the next frame
      n0 = nw; f0 = nfd;
      send_frame(8, 0, 0, 0, 3);
      pause = 1'b0; mode = 2'd0;
      chk("tog_writes", nw - n0, 128);
      chk("tog_done", nfd - f0, 1);
      chk("tog_dout_l3", wd[(n0 + 48) % 1024], 8'h30);
      chk("tog_dout_last", wd[(n0 + 127) % 1024], 8'h7F);
      chk("tog_cnt", frame_cnt, 5);

      // one line too many
      n0 = nw;
      send_frame(9, 0, 0, 0, -1);
      chk("ovf_writes", nw - n0, 128);
      chk("ovf_last_addr", wa[(n0 + 127) % 1024], 127);
      chk("ovf_flag", overflow, 1);
      chk("ovf_addr_hold", addr, 127);
      chk("ovf_cnt", frame_cnt, 6);

      n0 = nw;
      send_frame(8, 0, 0, 0, -1);
      chk("ovf_cleared", overflow, 0);
      chk("ovf_next_writes", nw - n0, 128);
      chk("full_line_err", line_err, 0);
      chk("ovf_next_cnt", frame_cnt, 7);

      // vsync rises in the middle of a line
      n0 = nw; f0 = nfd;
      send_frame(3, 0, 5, 0, -1);
      chk("abort_writes", nw - n0, 53);
      chk("abort_done", nfd - f0, 1);
      chk("abort_last", wd[(n0 + 52) % 1024], 8'h34);
      chk("abort_cnt", frame_cnt, 8);

      // short line
      n0 = nw;
      send_frame(7, 15, 0, 0, -1);
      chk("short_writes", nw - n0, 127);
`ifdef OV7670_CAPTURE_LINE_CHECK_EN
      chk("short_line_err", line_err, 1);
`else
      chk("short_line_err", line_err, 0);
`endif

      // asynchronous reset in mid-line
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
      for (int x = 0; x < 5; x++) send_pix(0, x, 0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_we", we, 0);
      chk("mrst_addr", addr, 0);
      chk("mrst_dout", dout, 0);
      chk("mrst_cnt", frame_cnt, 0);
      chk("mrst_line_err", line_err, 0);
      @(posedge pclk);
      #1 rst_n = 1'b1;
      n0 = nw;
      for (int x = 5; x < HRES; x++) send_pix(0, x, 0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
      send_line(1, HRES, 0);
      chk("mrst_no_writes", nw - n0, 0);

      n0 = nw;
      send_frame(8, 0, 0, 0, -1);
      chk("post_writes", nw - n0, 128);
      chk("post_dout", wd[(n0 + 100) % 1024], 100);
      chk("post_cnt", frame_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
